data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the pipeline's memory stage and the backing data memory. It accepts one load or store per cycle from the memory stage and returns load data combinationally on a hit. On a miss or store it drives `stall_o`, which freezes the whole pipeline. Line refills use a request/ready handshake followed by in-order data beats.

## Interface
- `DATA_WIDTH`, 32, word width in bits.
- `SETS`, 256, number of lines; must be a power of 2.
- `WORDS_PER_LINE`, 4, words per line; must be a power of 2.
- `clk  in  1  clock`
- `rst  in  1  synchronous, active-low reset`
- `cpu_rd_en_i  in  1  load request from the memory stage`
- `cpu_wr_en_i  in  1  store request from the memory stage`
- `cpu_addr_i  in  32  byte address; bits [1:0] are ignored`
- `cpu_wr_data_i  in  32  store data, already lane-aligned`
- `cpu_byte_en_i  in  4  store byte lanes`
- `cpu_rd_data_o  out  32  load word; sign-extension is done downstream`
- `stall_o  out  1  freezes the pipeline while high`
- `mem_req_o  out  1  backing-memory request valid`
- `mem_we_o  out  1  1 = write, 0 = line read`
- `mem_addr_o  out  32  line base address for a read; word address for a write`
- `mem_wr_data_o  out  32  write data`
- `mem_byte_en_o  out  4  write byte lanes`
- `mem_ready_i  in  1  request accepted in this cycle`
- `mem_rd_valid_i  in  1  refill data beat valid`
- `mem_rd_data_i  in  32  refill beat data`
- `hit_count_o  out  32  load hits, saturating`
- `miss_count_o  out  32  load misses, saturating`

## Operation
- Address split: offset = bits [1+log2(WORDS_PER_LINE):2], index = next log2(SETS) bits, tag = the remaining upper bits.
- Storage:
  - Per line: valid bit, tag, WORDS_PER_LINE data words.
  - Arrays are read combinationally and written on `clk`.
- States: IDLE, REFILL_REQ, REFILL_DATA, WRITE.
- IDLE, load hit (valid and tag match): `cpu_rd_data_o` = stored word; `stall_o`=0; `hit_count_o` increments.
- IDLE, load miss:
  - `stall_o`=1 in the same cycle.
  - Next state REFILL_REQ; `miss_count_o` increments once.
- REFILL_REQ:
  - `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o` = line base (offset bits and bits [1:0] zero).
  - Held stable until `mem_ready_i`=1, then go to REFILL_DATA with beat counter = 0.
- REFILL_DATA:
  - Each cycle with `mem_rd_valid_i`=1 writes word[counter] and increments the counter.
  - The last beat writes tag and sets valid, then returns to IDLE.
- Last-beat cycle:
  - `stall_o`=0 and `cpu_rd_data_o` = requested word.
  - If the requested word is the last word, it is bypassed from `mem_rd_data_i`; otherwise it comes from the array.
  - The pipeline advances at that edge.
  - The hit counter does not count the completing load.
- IDLE, store: `stall_o`=1; next state WRITE.
- WRITE:
  - `mem_req_o`=1, `mem_we_o`=1; `mem_addr_o` = `cpu_addr_i` with [1:0] zeroed; write data and byte enables come from the CPU.
  - In the cycle `mem_ready_i`=1: `stall_o`=0; if the line is valid and the tag matches, enabled bytes are merged into the cached word at that edge. Return to IDLE.
  - A store miss never allocates.
- Both `cpu_rd_en_i` and `cpu_wr_en_i` high: the store takes priority and the load is ignored.
- Neither high in IDLE: `stall_o`=0, no memory activity.
- A refill overwrites the resident line unconditionally; write-through means nothing is dirty.
- Counters saturate at 0xFFFFFFFF.

## Timing
- Reset (`rst`=0 at a rising edge):
  - All valid bits cleared; state IDLE; counters 0; beat counter 0.
  - Outputs `mem_req_o`=0, `mem_we_o`=0, `stall_o`=0 (with no request).
  - `mem_addr_o`, `mem_wr_data_o`, `mem_byte_en_o` = 0.
- Reset mid-refill or mid-write:
  - Aborts the operation; the partially filled line stays invalid.
  - Backing memory shares `rst` and discards its in-flight beats.
- Load hit latency: 0 extra cycles.
- Load miss, minimum case (ready on first request cycle, back-to-back beats):
  - Cycle 0 detect; cycle 1 request accepted; cycles 2–5 beats.
  - `stall_o` high in cycles 0–4, low in cycle 5: 5 stall cycles.
- Store, minimum case: cycle 0 detect; cycle 1 WRITE with `mem_ready_i`=1; 1 stall cycle.
- Backpressure: each cycle of `mem_ready_i`=0, or each gap in `mem_rd_valid_i`, adds one stall cycle. The request fields stay stable throughout.
- `mem_rd_valid_i` outside REFILL_DATA is ignored.

## Test plan
- Cold load at 0x00000104 with memory line words {A0,A1,A2,A3} at 0x100, ready immediate:
  - `stall_o` high for exactly 5 cycles.
  - `cpu_rd_data_o`=A1 on release; `miss_count_o`=1.
- Load at 0x0000010C on the next cycle: `cpu_rd_data_o`=A3, `stall_o`=0, `hit_count_o`=1.
- Store 0xDEADBEEF to 0x00000108 with `cpu_byte_en_i`=0b0011 and `mem_ready_i` delayed 3 cycles:
  - Memory write seen once; 4 stall cycles.
  - A following load of 0x108 hits and returns A2[31:16]:BEEF.
- Store to uncached 0x00000200: memory write is issued; a following load of 0x200 still misses (no allocate).
- Conflict eviction: load 0x00001104 after 0x104 is resident (same index, different tag):
  - Refill occurs, then load 0x104 misses again.
  - `miss_count_o` increments each time.
- Reset asserted during the 3rd refill beat:
  - `mem_req_o`=0, `stall_o`=0, counters 0.
  - A subsequent load of the same address misses.

Source files
------------

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache
//
// Parameters: DATA_WIDTH word width, SETS line count, WORDS_PER_LINE words per line.
// Ports:
//   clk, rst (sync, active-low)
//   cpu_*   : one load/store per cycle from the memory stage, load word out,
//             stall_o freezes the pipeline
//   mem_*   : backing-memory request/ready handshake plus in-order refill beats
//   hit_count_o / miss_count_o : saturating load hit/miss counters
module data_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 256,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_rd_en_i,
  input  logic                    cpu_wr_en_i,
  input  logic [31:0]             cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]   cpu_wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] cpu_byte_en_i,
  output logic [DATA_WIDTH-1:0]   cpu_rd_data_o,
  output logic                    stall_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [31:0]             mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wr_data_o,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_rd_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data_i,
  output logic [31:0]             hit_count_o,
  output logic [31:0]             miss_count_o
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - 2 - OFF_W - IDX_W;
  localparam int LINE_W = IDX_W + OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_DATA, WRITE} state_t;

  state_t state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS*WORDS_PER_LINE];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [LINE_W-1:0] rd_sel, fill_sel;
  logic              hit;
  logic              fill_we, fill_done, merge_we, hit_inc, miss_inc;

  // Byte-lane bits of the address never select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign off      = cpu_addr_i[OFF_W+1:2];
  assign idx      = cpu_addr_i[OFF_W+IDX_W+1:OFF_W+2];
  assign tag      = cpu_addr_i[31:OFF_W+IDX_W+2];
  assign rd_sel   = {idx, off};
  assign fill_sel = {idx, beat_q};
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  // The pipeline is frozen while stalled, so cpu_addr_i stays valid as the
  // miss/store address for the whole multi-cycle operation.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    stall_o       = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    mem_byte_en_o = '0;
    cpu_rd_data_o = data_q[rd_sel];
    fill_we       = 1'b0;
    fill_done     = 1'b0;
    merge_we      = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_wr_en_i) begin
          stall_o = 1'b1;
          state_d = WRITE;
        end else if (cpu_rd_en_i) begin
          if (hit) begin
            hit_inc = 1'b1;
          end else begin
            stall_o  = 1'b1;
            miss_inc = 1'b1;
            state_d  = REFILL_REQ;
          end
        end
      end
      REFILL_REQ: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {cpu_addr_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        if (mem_ready_i) begin
          state_d = REFILL_DATA;
          beat_d  = '0;
        end
      end
      REFILL_DATA: begin
        stall_o = 1'b1;
        if (mem_rd_valid_i) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            // Release on the last beat; earlier words are already in the
            // array, the last one only exists on the refill bus this cycle.
            fill_done = 1'b1;
            stall_o   = 1'b0;
            state_d   = IDLE;
            if (off == LAST_BEAT) cpu_rd_data_o = mem_rd_data_i;
          end
        end
      end
      WRITE: begin
        stall_o       = 1'b1;
        mem_req_o     = 1'b1;
        mem_we_o      = 1'b1;
        mem_addr_o    = {cpu_addr_i[31:2], 2'b00};
        mem_wr_data_o = cpu_wr_data_i;
        mem_byte_en_o = cpu_byte_en_i;
        if (mem_ready_i) begin
          stall_o  = 1'b0;
          merge_we = hit;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      valid_q      <= '0;
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (fill_done) valid_q[idx] <= 1'b1;
      if (hit_inc && hit_count_o != 32'hFFFF_FFFF) hit_count_o <= hit_count_o + 32'd1;
      if (miss_inc && miss_count_o != 32'hFFFF_FFFF) miss_count_o <= miss_count_o + 32'd1;
    end
  end

  // Tag/data arrays carry no reset; valid_q alone decides residency.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (fill_done) tag_q[idx] <= tag;
      if (fill_we) data_q[fill_sel] <= mem_rd_data_i;
      if (merge_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (cpu_byte_en_i[b]) data_q[rd_sel][8*b +: 8] <= cpu_wr_data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - self-checking bench for data_cache
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_en_i, cpu_wr_en_i;
  logic [31:0] cpu_addr_i, cpu_wr_data_i;
  logic [3:0]  cpu_byte_en_i;
  logic [31:0] cpu_rd_data_o;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wr_data_o;
  logic [3:0]  mem_byte_en_o;
  logic        mem_ready_i, mem_rd_valid_i;
  logic [31:0] mem_rd_data_i;
  logic [31:0] hit_count_o, miss_count_o;

  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .rst(rst),
    .cpu_rd_en_i(cpu_rd_en_i), .cpu_wr_en_i(cpu_wr_en_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wr_data_i(cpu_wr_data_i),
    .cpu_byte_en_i(cpu_byte_en_i), .cpu_rd_data_o(cpu_rd_data_o),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_byte_en_o(mem_byte_en_o), .mem_ready_i(mem_ready_i),
    .mem_rd_valid_i(mem_rd_valid_i), .mem_rd_data_i(mem_rd_data_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- backing memory model ----------------
  logic [31:0] mem [logic [31:0]];
  int          ready_delay  = 0;
  int          wait_cnt     = 0;
  int          beats_left   = 0;
  logic [31:0] beat_addr    = '0;
  int          mem_writes   = 0;
  logic [31:0] last_rd_addr = '0;
  logic        rec_rst = 1'b0, rec_req = 1'b0, rec_ready = 1'b0, rec_we = 1'b0, rec_beat = 1'b0;
  logic [31:0] rec_addr = '0, rec_wdata = '0;
  logic [3:0]  rec_be = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h5A5A_0000 ^ a;
  endfunction

  initial begin
    logic [31:0] w;
    mem_ready_i    = 1'b0;
    mem_rd_valid_i = 1'b0;
    mem_rd_data_i  = '0;
    forever begin
      @(posedge clk);
      if (!rec_rst) begin
        beats_left = 0;
        wait_cnt   = 0;
      end else begin
        if (rec_beat) begin
          beats_left--;
          beat_addr += 4;
        end
        if (rec_req && rec_ready) begin
          wait_cnt = 0;
          if (rec_we) begin
            w = mem_rd(rec_addr);
            for (int b = 0; b < 4; b++) if (rec_be[b]) w[8*b +: 8] = rec_wdata[8*b +: 8];
            mem[rec_addr] = w;
            mem_writes++;
          end else begin
            beats_left   = 4;
            beat_addr    = rec_addr;
            last_rd_addr = rec_addr;
          end
        end else if (rec_req) begin
          wait_cnt++;
        end
      end
      #2;
      mem_rd_valid_i = (beats_left > 0);
      mem_rd_data_i  = (beats_left > 0) ? mem_rd(beat_addr) : 32'h0;
      mem_ready_i    = mem_req_o && (wait_cnt >= ready_delay) && (beats_left == 0);
      @(negedge clk);
      rec_rst   = rst;
      rec_req   = mem_req_o;
      rec_ready = mem_ready_i;
      rec_we    = mem_we_o;
      rec_addr  = mem_addr_o;
      rec_wdata = mem_wr_data_o;
      rec_be    = mem_byte_en_o;
      rec_beat  = mem_rd_valid_i;
    end
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;
    int          exp_stall;
    logic [31:0] exp_data;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
    int          exp_wr;
  } vec_t;

  vec_t vecs[15];
  vec_t sb[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be, input int delay,
                              input int stall, input logic [31:0] data, input logic [31:0] hits,
                              input logic [31:0] misses, input int wrs);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.delay = delay;
    v.exp_stall = stall; v.exp_data = data; v.exp_hits = hits; v.exp_misses = misses;
    v.exp_wr = wrs;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   wr0;
    int   stalls;
    bit   done;
    tick();
    wr0           = mem_writes;
    stalls        = 0;
    done          = 1'b0;
    ready_delay   = v.delay;
    cpu_rd_en_i   = v.rd;
    cpu_wr_en_i   = v.wr;
    cpu_addr_i    = v.addr;
    cpu_wr_data_i = v.wdata;
    cpu_byte_en_i = v.be;
    sb.push_back(v);
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (stall_o) begin
        stalls++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    e = sb.pop_front();
    check("release_before_timeout", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(e.exp_stall));
    if (e.rd && !e.wr) check("rd_data", cpu_rd_data_o, e.exp_data);
    tick();
    cpu_rd_en_i = 1'b0;
    cpu_wr_en_i = 1'b0;
    ready_delay = 0;
    @(negedge clk);
    check("hit_count", hit_count_o, e.exp_hits);
    check("miss_count", miss_count_o, e.exp_misses);
    check("mem_writes", 32'(mem_writes - wr0), 32'(e.exp_wr));
    if (e.rd && !e.wr && e.exp_stall > 0) check("refill_addr", last_rd_addr, e.addr & ~32'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    mem[32'h100] = 32'hA000_0000;
    mem[32'h104] = 32'hA000_0001;
    mem[32'h108] = 32'hA000_0002;
    mem[32'h10C] = 32'hA000_0003;

    //              rd    wr    addr          wdata         be     dly stall data          hits misses wr
    vecs[0]  = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0,        4'h0, 0, 0, 32'h0,        0, 0, 0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 0, 5, 32'hA000_0001, 0, 1, 0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0000_010C, 32'h0,        4'h0, 0, 0, 32'hA000_0003, 1, 1, 0);
    vecs[3]  = mk(1'b0, 1'b1, 32'h0000_0108, 32'hDEADBEEF, 4'h3, 3, 4, 32'h0,        1, 1, 1);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0000_0108, 32'h0,        4'h0, 0, 0, 32'hA000_BEEF, 2, 1, 0);
    vecs[5]  = mk(1'b0, 1'b1, 32'h0000_0200, 32'h12345678, 4'hF, 0, 1, 32'h0,        2, 1, 1);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0000_0200, 32'h0,        4'h0, 0, 5, 32'h1234_5678, 2, 2, 0);
    vecs[7]  = mk(1'b1, 1'b0, 32'h0000_1104, 32'h0,        4'h0, 0, 5, 32'h5A5A_1104, 2, 3, 0);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 0, 5, 32'hA000_0001, 2, 4, 0);
    vecs[9]  = mk(1'b1, 1'b1, 32'h0000_010C, 32'hCAFEF00D, 4'hC, 1, 2, 32'h0,        2, 4, 1);
    vecs[10] = mk(1'b1, 1'b0, 32'h0000_010C, 32'h0,        4'h0, 0, 0, 32'hCAFE_0003, 3, 4, 0);
    vecs[11] = mk(1'b1, 1'b0, 32'h0000_2008, 32'h0,        4'h0, 2, 7, 32'h5A5A_2008, 3, 5, 0);
    vecs[12] = mk(1'b1, 1'b0, 32'h0000_200C, 32'h0,        4'h0, 0, 0, 32'h5A5A_200C, 4, 5, 0);
    vecs[13] = mk(1'b1, 1'b0, 32'h0000_030C, 32'h0,        4'h0, 0, 5, 32'h5A5A_030C, 4, 6, 0);
    vecs[14] = mk(1'b1, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 0, 0, 32'hA000_0001, 5, 6, 0);

    rst           = 1'b0;
    cpu_rd_en_i   = 1'b0;
    cpu_wr_en_i   = 1'b0;
    cpu_addr_i    = '0;
    cpu_wr_data_i = '0;
    cpu_byte_en_i = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_mem_req", 32'(mem_req_o), 32'd0);
    check("reset_mem_we", 32'(mem_we_o), 32'd0);
    check("reset_mem_addr", mem_addr_o, 32'd0);
    check("reset_mem_wr_data", mem_wr_data_o, 32'd0);
    check("reset_mem_byte_en", 32'(mem_byte_en_o), 32'd0);
    check("reset_hits", hit_count_o, 32'd0);
    check("reset_misses", miss_count_o, 32'd0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Reset during the third refill beat of a miss on 0x404.
    tick();
    cpu_rd_en_i = 1'b1;
    cpu_addr_i  = 32'h0000_0404;
    repeat (4) tick();
    rst         = 1'b0;
    cpu_rd_en_i = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem_req", 32'(mem_req_o), 32'd0);
    check("abort_stall", 32'(stall_o), 32'd0);
    check("abort_hits", hit_count_o, 32'd0);
    check("abort_misses", miss_count_o, 32'd0);
    run_vec(mk(1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'h0, 0, 5, 32'h5A5A_0404, 0, 1, 0));
    run_vec(mk(1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'h0, 0, 0, 32'h5A5A_0404, 1, 1, 0));
    // Previously resident line must be gone after the reset.
    run_vec(mk(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 5, 32'hA000_0001, 1, 2, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
